bp_be_stride_detector: RTL and testbench
========================================

Name: bp_be_stride_detector

Overview:
- Producer side of the striding-load interface; its downstream consumer is the backend prefetch generator.
- Observes committed integer loads and tracks per-PC address deltas in a direct-mapped reference table.
- Once a stride is confirmed, issues one request: pc, start address, stride and loop count.
- The request is held stable under a valid/ready handshake until the generator accepts it.

Parameters:
- vaddr_width_p, from bp_params_p: virtual address width.
- entries_p, 16: table entries; power of two, at least 2.
- loop_range_p, 8: width of loop_counter_o.
- stride_width_p, 8: signed stride width.
- conf_threshold_p, 2: matching deltas required before issue; at least 1.
- degree_p, 8: loop count sent per request; 1 to 2^loop_range_p-1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- commit_v_i  in  1  committed integer load this cycle
- commit_pc_i  in  vaddr_width_p  load PC
- commit_eff_addr_i  in  vaddr_width_p  load effective address
- clear_i  in  1  invalidate whole table (fence/sfence/satp write)
- v_o  out  1  request valid
- ready_and_i  in  1  consumer ready
- pc_o  out  vaddr_width_p  request PC
- eff_addr_o  out  vaddr_width_p  first prefetch address
- stride_o  out  stride_width_p  signed stride
- loop_counter_o  out  loop_range_p  prefetch count
- drop_o  out  1  one-cycle pulse: trigger lost because the buffer was full

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is asynchronous and active-high.
- Reset: all entry valid bits, v_o and drop_o go to 0 immediately. Other data outputs hold 0. Reset mid-handshake discards the pending request.
- Table addressing:
  - index = commit_pc_i[2 +: lg(entries_p)]
  - tag = commit_pc_i[vaddr_width_p-1 : 2+lg(entries_p)]
- Entry fields: valid, tag, last_addr, stride, conf (saturating at conf_threshold_p), cooldown (loop_range_p bits).
- delta = commit_eff_addr_i - last_addr, computed modulo 2^vaddr_width_p.
- delta fits when sign-extending its low stride_width_p bits reproduces delta exactly.
- On commit_v_i, miss: allocate the entry (overwrite on conflict) with tag, last_addr=addr, stride=0, conf=0, cooldown=0.
- On commit_v_i, hit:
  - Always: last_addr<=addr.
  - match (fits, delta!=0, delta==stride): conf saturating-increments; if cooldown!=0 then cooldown--.
  - otherwise: stride<=delta if it fits, else 0; conf<=0; cooldown<=0.
- Trigger condition: hit, match, next conf==conf_threshold_p, and cooldown==0.
  - Request built: pc=commit_pc_i, eff_addr=addr+sext(stride), stride, loop_counter=degree_p.
  - Request enters the output buffer registered, so v_o rises in cycle t+1 for a commit in cycle t.
  - On accept into the buffer, cooldown<=degree_p-1.
- Output buffer, one entry, states EMPTY/FULL:
  - EMPTY -> FULL on trigger.
  - FULL -> EMPTY on v_o & ready_and_i with no trigger.
  - FULL stays FULL on handshake plus trigger in the same cycle (new request loaded).
  - FULL with no handshake plus trigger: trigger dropped, drop_o=1 in t+1, cooldown not reloaded (retries on the next match).
- While v_o=1, all request outputs hold stable.
- clear_i: all valid bits cleared next edge. It wins over a same-cycle commit, which is ignored. It does not affect the output buffer.
- Addresses wrap modulo 2^vaddr_width_p with no saturation.

Optional Feature:
- Macro: BP_BE_STRIDE_DETECTOR_DEDUP_EN.
- Defined: a trigger whose pc and stride equal the request currently held in a FULL buffer updates eff_addr in place. There is no drop_o and cooldown is reloaded.
- Undefined: standard drop behaviour as above.

Decomposition:
- bp_be_pkg additions:
  - bp_be_stride_entry_s and bp_be_stride_req_s, parameterized by vaddr_width_p and stride_width_p.
  - Width macros for both structs.
- Sub-module bp_be_stride_req_buffer:
  - one-entry, asynchronous-reset valid/ready holding register of bp_be_stride_req_s.
  - provides drop detection.
- The table stays in the top module as flop arrays.

Test Plan (all defaults):
- Commit loads at pc 0x80001000 with addresses 0x1000, 0x1008, 0x1010, 0x1018, ready_and_i=1 -> exactly one v_o, the cycle after the 4th commit: eff_addr_o=0x1020, stride_o=8, loop_counter_o=8.
- Continue the same stream through 0x1058 -> no further v_o until the 8th matching load after issue; second request has eff_addr_o=0x1060.
- Negative stride: addresses 0x2000, 0x1FF0, 0x1FE0, 0x1FD0 -> stride_o=0xF0, eff_addr_o=0x1FC0. Then delta 0x200 -> conf and stride reset to 0, no issue.
- Hold ready_and_i=0 while two different PCs trigger -> the first request holds stable, drop_o pulses once. Raise ready_and_i -> handshake, buffer EMPTY.
- clear_i the same cycle as a triggering commit -> no v_o. The next commit at that PC misses and allocates.
- Assert reset_i asynchronously while v_o=1 -> v_o=0 immediately; after release no request appears until a re-trained stream triggers.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Backend shared types for the striding-load detector.
// Struct declaration and width macros for table entries and requests.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`define DECLARE_BP_BE_STRIDE_ENTRY_S(tag_w, vaddr_w, stride_w, conf_w, loop_w) \
    typedef struct packed {                 \
        logic                valid;         \
        logic [tag_w-1:0]    tag;           \
        logic [vaddr_w-1:0]  last_addr;     \
        logic [stride_w-1:0] stride;        \
        logic [conf_w-1:0]   conf;          \
        logic [loop_w-1:0]   cooldown;      \
    } bp_be_stride_entry_s

`define BP_BE_STRIDE_ENTRY_WIDTH(tag_w, vaddr_w, stride_w, conf_w, loop_w) \
    (1 + (tag_w) + (vaddr_w) + (stride_w) + (conf_w) + (loop_w))

`define DECLARE_BP_BE_STRIDE_REQ_S(vaddr_w, stride_w, loop_w) \
    typedef struct packed {                 \
        logic [vaddr_w-1:0]  pc;            \
        logic [vaddr_w-1:0]  eff_addr;      \
        logic [stride_w-1:0] stride;        \
        logic [loop_w-1:0]   loop_counter;  \
    } bp_be_stride_req_s

`define BP_BE_STRIDE_REQ_WIDTH(vaddr_w, stride_w, loop_w) \
    (2 * (vaddr_w) + (stride_w) + (loop_w))

package bp_be_pkg;

    typedef enum logic {
        e_stride_buf_empty,
        e_stride_buf_full
    } bp_be_stride_buf_state_e;

endpackage

`endif

// File: rtl/bp_be_stride_req_buffer.sv
// One-entry valid/ready holding register for stride requests.
// BP_BE_STRIDE_DETECTOR_DEDUP_EN: same pc/stride refreshes in place.
module bp_be_stride_req_buffer
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int loop_range_p   = 8,
    localparam int req_width_lp  =
        `BP_BE_STRIDE_REQ_WIDTH(vaddr_width_p, stride_width_p, loop_range_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    trig_v_i,
    input  logic [req_width_lp-1:0] req_i,
    input  logic                    ready_and_i,
    output logic                    v_o,
    output logic [req_width_lp-1:0] req_o,
    output logic                    accept_o,
    output logic                    drop_o
);

    `DECLARE_BP_BE_STRIDE_REQ_S(vaddr_width_p, stride_width_p, loop_range_p);

    bp_be_stride_buf_state_e state_r, state_n;
    logic [req_width_lp-1:0] req_r;
    logic                    drop_r, drop_n;
    logic                    hs;
    logic                    same;

`ifdef BP_BE_STRIDE_DETECTOR_DEDUP_EN
    bp_be_stride_req_s cur_req, new_req;
    assign cur_req = req_r;
    assign new_req = req_i;
    assign same = (cur_req.pc == new_req.pc)
                & (cur_req.stride == new_req.stride);
`else
    assign same = 1'b0;
`endif

    // Next state, load strobe and drop detection
    always_comb begin
        state_n  = state_r;
        accept_o = 1'b0;
        drop_n   = 1'b0;
        hs       = 1'b0;
        unique case (state_r)
            e_stride_buf_empty: begin
                if (trig_v_i) begin
                    accept_o = 1'b1;
                    state_n  = e_stride_buf_full;
                end
            end
            e_stride_buf_full: begin
                hs = ready_and_i;
                if (trig_v_i & (hs | same)) begin
                    accept_o = 1'b1;
                end else if (trig_v_i) begin
                    drop_n = 1'b1;
                end else if (hs) begin
                    state_n = e_stride_buf_empty;
                end
            end
        endcase
    end

    // Buffer state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_stride_buf_empty;
        else         state_r <= state_n;
    end

    // Request payload and drop pulse
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_r  <= '0;
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_n;
            if (accept_o) req_r <= req_i;
        end
    end

    assign v_o    = (state_r == e_stride_buf_full);
    assign req_o  = req_r;
    assign drop_o = drop_r;

endmodule

// File: rtl/bp_be_stride_detector.sv
// Per-PC stride detector feeding the backend prefetch generator.
// BP_BE_STRIDE_DETECTOR_DEDUP_EN: refresh held request on repeat.
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int entries_p        = 16,
    parameter int loop_range_p     = 8,
    parameter int stride_width_p   = 8,
    parameter int conf_threshold_p = 2,
    parameter int degree_p         = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      commit_v_i,
    input  logic [vaddr_width_p-1:0]  commit_pc_i,
    input  logic [vaddr_width_p-1:0]  commit_eff_addr_i,
    input  logic                      clear_i,
    output logic                      v_o,
    input  logic                      ready_and_i,
    output logic [vaddr_width_p-1:0]  pc_o,
    output logic [vaddr_width_p-1:0]  eff_addr_o,
    output logic [stride_width_p-1:0] stride_o,
    output logic [loop_range_p-1:0]   loop_counter_o,
    output logic                      drop_o
);

    localparam int lg_lp    = $clog2(entries_p);
    localparam int tag_w_lp = vaddr_width_p - 2 - lg_lp;
    localparam int conf_lp  = $clog2(conf_threshold_p + 1);
    localparam int ext_lp   = vaddr_width_p - stride_width_p;
    localparam int ent_w_lp = `BP_BE_STRIDE_ENTRY_WIDTH(
        tag_w_lp, vaddr_width_p, stride_width_p, conf_lp, loop_range_p);
    localparam int req_w_lp = `BP_BE_STRIDE_REQ_WIDTH(
        vaddr_width_p, stride_width_p, loop_range_p);

    localparam logic [conf_lp-1:0] thr_lp = conf_lp'(conf_threshold_p);
    localparam logic [loop_range_p-1:0] deg_lp = loop_range_p'(degree_p);
    localparam logic [loop_range_p-1:0] cool_lp =
        loop_range_p'(degree_p - 1);

    `DECLARE_BP_BE_STRIDE_ENTRY_S(
        tag_w_lp, vaddr_width_p, stride_width_p, conf_lp, loop_range_p);
    `DECLARE_BP_BE_STRIDE_REQ_S(vaddr_width_p, stride_width_p, loop_range_p);

    logic [ent_w_lp-1:0] tbl_r [entries_p];

    logic [lg_lp-1:0]          idx;
    logic [tag_w_lp-1:0]       tag;
    bp_be_stride_entry_s       ent, ent_n;
    bp_be_stride_req_s         req, req_out;
    logic [req_w_lp-1:0]       buf_req;
    logic [vaddr_width_p-1:0]  delta, delta_sext, stride_ext;
    logic [conf_lp-1:0]        conf_n;
    logic                      hit, fits, match, trig, accept;

    assign idx = commit_pc_i[2 +: lg_lp];
    assign tag = commit_pc_i[vaddr_width_p-1 : 2+lg_lp];
    assign ent = tbl_r[idx];

    // Delta classification against the indexed entry
    always_comb begin
        delta      = commit_eff_addr_i - ent.last_addr;
        delta_sext = {{ext_lp{delta[stride_width_p-1]}},
                      delta[stride_width_p-1:0]};
        stride_ext = {{ext_lp{ent.stride[stride_width_p-1]}},
                      ent.stride};
        hit    = ent.valid & (ent.tag == tag);
        fits   = (delta_sext == delta);
        match  = fits & (|delta) & (delta == stride_ext);
        conf_n = '0;
        if (match) begin
            conf_n = (ent.conf == thr_lp) ? ent.conf : ent.conf + 1'b1;
        end
        trig = commit_v_i & ~clear_i & hit & match
             & (conf_n == thr_lp) & ~|ent.cooldown;
    end

    // Request built from the triggering commit
    always_comb begin
        req.pc           = commit_pc_i;
        req.eff_addr     = commit_eff_addr_i + stride_ext;
        req.stride       = ent.stride;
        req.loop_counter = deg_lp;
    end

    // Entry update: allocate on miss, train on hit
    always_comb begin
        ent_n = ent;
        if (!hit) begin
            ent_n.valid     = 1'b1;
            ent_n.tag       = tag;
            ent_n.last_addr = commit_eff_addr_i;
            ent_n.stride    = '0;
            ent_n.conf      = '0;
            ent_n.cooldown  = '0;
        end else begin
            ent_n.last_addr = commit_eff_addr_i;
            ent_n.conf      = conf_n;
            if (match) begin
                if (accept) begin
                    ent_n.cooldown = cool_lp;
                end else if (|ent.cooldown) begin
                    ent_n.cooldown = ent.cooldown - 1'b1;
                end
            end else begin
                ent_n.stride   = fits ? delta[stride_width_p-1:0] : '0;
                ent_n.cooldown = '0;
            end
        end
    end

    // Reference table; clear beats a same-cycle commit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < entries_p; i++) tbl_r[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < entries_p; i++) tbl_r[i] <= '0;
        end else if (commit_v_i) begin
            tbl_r[idx] <= ent_n;
        end
    end

    bp_be_stride_req_buffer #(
        .vaddr_width_p  (vaddr_width_p),
        .stride_width_p (stride_width_p),
        .loop_range_p   (loop_range_p)
    ) req_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .trig_v_i    (trig),
        .req_i       (req),
        .ready_and_i (ready_and_i),
        .v_o         (v_o),
        .req_o       (buf_req),
        .accept_o    (accept),
        .drop_o      (drop_o)
    );

    assign req_out        = buf_req;
    assign pc_o           = req_out.pc;
    assign eff_addr_o     = req_out.eff_addr;
    assign stride_o       = req_out.stride;
    assign loop_counter_o = req_out.loop_counter;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Testbench for bp_be_stride_detector: directed plan plus random
// streams checked against a behavioural model of the detector.
module tb_bp_be_stride_detector;

    localparam int W = 39;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         commit_v_i = 1'b0;
    logic [W-1:0] commit_pc_i = '0;
    logic [W-1:0] commit_eff_addr_i = '0;
    logic         clear_i = 1'b0;
    logic         ready_and_i = 1'b0;
    logic         v_o, drop_o;
    logic [W-1:0] pc_o, eff_addr_o;
    logic [7:0]   stride_o, loop_counter_o;

    bp_be_stride_detector #(.vaddr_width_p(W)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .commit_v_i        (commit_v_i),
        .commit_pc_i       (commit_pc_i),
        .commit_eff_addr_i (commit_eff_addr_i),
        .clear_i           (clear_i),
        .v_o               (v_o),
        .ready_and_i       (ready_and_i),
        .pc_o              (pc_o),
        .eff_addr_o        (eff_addr_o),
        .stride_o          (stride_o),
        .loop_counter_o    (loop_counter_o),
        .drop_o            (drop_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // model: table keyed by pc index, one-slot request buffer
    bit           m_valid [16];
    logic [W-1:0] m_tag   [16];
    logic [W-1:0] m_last  [16];
    int           m_str   [16];
    int           m_conf  [16];
    int           m_cool  [16];
    bit           m_v, m_drop;
    logic [W-1:0] m_pc, m_eff;
    int           m_bstr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i] = '0;
            m_last[i] = '0;
            m_str[i] = 0;
            m_conf[i] = 0;
            m_cool[i] = 0;
        end
        m_v = 0;
        m_drop = 0;
        m_pc = '0;
        m_eff = '0;
        m_bstr = 0;
    endtask

    task automatic model_step(input bit v, input logic [W-1:0] pc,
                              input logic [W-1:0] addr,
                              input bit clr, input bit rdy);
        int i;
        bit hit, fits, match, trig, take, same, hs;
        logic [W-1:0] d, e;
        longint sd, s;
        int nc;
        i = int'((pc >> 2) % 16);
        hs = m_v && rdy;
        trig = 0;
        take = 0;
        if (v && !clr) begin
            hit = m_valid[i] && (m_tag[i] == (pc >> 6));
            if (!hit) begin
                m_valid[i] = 1;
                m_tag[i] = pc >> 6;
                m_last[i] = addr;
                m_str[i] = 0;
                m_conf[i] = 0;
                m_cool[i] = 0;
            end else begin
                d = addr - m_last[i];
                sd = longint'(d);
                if (d[W-1]) sd = sd - (longint'(1) << W);
                fits = (sd >= -128) && (sd <= 127);
                match = fits && (sd != 0) && (sd == longint'(m_str[i]));
                nc = match ? ((m_conf[i] >= 1) ? 2 : m_conf[i] + 1) : 0;
                trig = match && (nc == 2) && (m_cool[i] == 0);
                if (trig) begin
`ifdef BP_BE_STRIDE_DETECTOR_DEDUP_EN
                    same = m_v && (m_pc == pc) && (m_bstr == m_str[i]);
`else
                    same = 0;
`endif
                    take = !m_v || hs || same;
                end
                if (take) begin
                    s = longint'(m_str[i]);
                    e = addr + s[W-1:0];
                    m_pc = pc;
                    m_eff = e;
                    m_bstr = m_str[i];
                end
                m_last[i] = addr;
                m_conf[i] = nc;
                if (match) begin
                    if (take) m_cool[i] = 7;
                    else if (m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
                end else begin
                    m_str[i] = fits ? int'(sd) : 0;
                    m_cool[i] = 0;
                end
            end
        end
        if (take) m_v = 1;
        else if (hs) m_v = 0;
        m_drop = trig && !take;
        if (clr) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [W-1:0] pc,
                         input logic [W-1:0] addr,
                         input bit clr, input bit rdy);
        logic [7:0] se;
        commit_v_i = v;
        commit_pc_i = pc;
        commit_eff_addr_i = addr;
        clear_i = clr;
        ready_and_i = rdy;
        model_step(v, pc, addr, clr, rdy);
        @(posedge clk_i);
        #1;
        chk("v_o", v_o, m_v);
        chk("drop_o", drop_o, m_drop);
        if (m_v) begin
            se = m_bstr[7:0];
            chk("pc_o", pc_o, m_pc);
            chk("eff_addr_o", eff_addr_o, m_eff);
            chk("stride_o", stride_o, se);
            chk("loop_counter_o", loop_counter_o, 8);
        end
    endtask

    logic [W-1:0] rpc [8];
    logic [W-1:0] cur [8];
    int           rst [8];

    initial begin
        logic [W-1:0] pa, pb, pcc, pd, pe, pf;
        model_reset();

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_v", v_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_eff", eff_addr_o, 0);
        chk("rst_stride", stride_o, 0);
        chk("rst_loop", loop_counter_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // basic +8 stream, first issue
        pa = 39'h0080001000;
        for (int k = 0; k < 4; k++) begin
            cycle(1, pa, 39'h1000 + 39'(8 * k), 0, 1);
            if (k < 3) chk("a_early", v_o, 0);
        end
        chk("a_v", v_o, 1);
        chk("a_eff", eff_addr_o, 39'h1020);
        chk("a_stride", stride_o, 8);
        chk("a_loop", loop_counter_o, 8);

        // cooldown: next issue on 8th match after the first
        for (int k = 4; k < 12; k++) begin
            cycle(1, pa, 39'h1000 + 39'(8 * k), 0, 1);
            if (k < 11) chk("a_cool", v_o, 0);
        end
        chk("a2_v", v_o, 1);
        chk("a2_eff", eff_addr_o, 39'h1060);

        // negative stride, then oversized delta retrains
        pb = 39'h0080002000;
        cycle(1, pb, 39'h2000, 0, 1);
        cycle(1, pb, 39'h1FF0, 0, 1);
        cycle(1, pb, 39'h1FE0, 0, 1);
        cycle(1, pb, 39'h1FD0, 0, 1);
        chk("b_v", v_o, 1);
        chk("b_stride", stride_o, 8'hF0);
        chk("b_eff", eff_addr_o, 39'h1FC0);
        cycle(1, pb, 39'h21D0, 0, 1);
        chk("b_big", v_o, 0);
        cycle(1, pb, 39'h21E0, 0, 1);
        cycle(1, pb, 39'h21F0, 0, 1);
        chk("b_retrain", v_o, 0);

        // full buffer: second trigger dropped, first held
        pcc = 39'h0080003010;
        pd  = 39'h0080004024;
        for (int k = 0; k < 3; k++) begin
            cycle(1, pcc, 39'h3000 + 39'(4 * k), 0, 0);
            cycle(1, pd, 39'h5000 + 39'(4 * k), 0, 0);
        end
        cycle(1, pcc, 39'h300C, 0, 0);
        chk("c_v", v_o, 1);
        chk("c_pc", pc_o, pcc);
        cycle(1, pd, 39'h500C, 0, 0);
        chk("c_drop", drop_o, 1);
        chk("c_hold_pc", pc_o, pcc);
        chk("c_hold_eff", eff_addr_o, 39'h3010);
        cycle(0, '0, '0, 0, 0);
        chk("c_drop_pulse", drop_o, 0);
        chk("c_still_v", v_o, 1);
        cycle(0, '0, '0, 0, 1);
        chk("c_empty", v_o, 0);

        // clear wins over a triggering commit
        pe = 39'h0080005008;
        for (int k = 0; k < 3; k++) cycle(1, pe, 39'h7000 + 39'(32 * k), 0, 1);
        cycle(1, pe, 39'h7060, 1, 1);
        chk("e_clr", v_o, 0);
        cycle(1, pe, 39'h7080, 0, 1);
        cycle(1, pe, 39'h70A0, 0, 1);
        cycle(1, pe, 39'h70C0, 0, 1);
        chk("e_alloc", v_o, 0);
        cycle(1, pe, 39'h70E0, 0, 1);
        chk("e_retrig", v_o, 1);

        // async reset while a request is pending
        pf = 39'h008000600C;
        for (int k = 0; k < 4; k++) cycle(1, pf, 39'h9000 + 39'(64 * k), 0, 0);
        chk("f_v", v_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("f_rst_v", v_o, 0);
        chk("f_rst_pc", pc_o, 0);
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        cycle(1, pf, 39'h9100, 0, 1);
        cycle(1, pf, 39'h9140, 0, 1);
        cycle(1, pf, 39'h9180, 0, 1);
        chk("f_quiet", v_o, 0);
        cycle(1, pf, 39'h91C0, 0, 1);
        chk("f_retrig", v_o, 1);
        chk("f_eff", eff_addr_o, 39'h9200);

        // random streams, aliasing pcs, wrap, clears, backpressure
        rst = '{8, -4, 16, 64, 127, -128, 200, 4};
        for (int p = 0; p < 6; p++) rpc[p] = 39'h0080010000 + 39'(4 * p);
        rpc[6] = 39'h0080010040;
        rpc[7] = 39'h0080020004;
        for (int p = 0; p < 8; p++) cur[p] = 39'(32'($urandom));
        cur[0] = 39'h7FFFFFFF00;
        for (int n = 0; n < 3000; n++) begin
            int p;
            bit v, clr, rdy;
            longint s;
            p = int'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            if (v) begin
                if ($urandom_range(0, 7) == 0) begin
                    cur[p] = 39'({$urandom, $urandom});
                end else begin
                    s = longint'(rst[p]);
                    cur[p] = cur[p] + s[W-1:0];
                end
            end
            cycle(v, rpc[p], cur[p], clr, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
